// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store initiator for the byte-addressable data memory, with
//            alignment trapping and load extension. Optional statistics
//            counters are enabled by defining MAU_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int STAT_WIDTH       = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [1:0]                  req_size,
    input  logic                        req_signed,
    input  logic [ADDRESS_WIDTH-1:0]    req_addr,
    input  logic [INSTR_DATA_WIDTH-1:0] req_wdata,
    output logic                        resp_valid,
    output logic [INSTR_DATA_WIDTH-1:0] resp_rdata,
    output logic                        resp_misalign,
    output logic [ADDRESS_WIDTH-1:0]    mem_addr,
    output logic [INSTR_DATA_WIDTH-1:0] mem_data,
    output logic                        mem_w_en,
    output logic [1:0]                  mem_sel,
    input  logic [INSTR_DATA_WIDTH-1:0] mem_rdata
`ifdef MAU_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]       stat_loads,
    output logic [STAT_WIDTH-1:0]       stat_stores,
    output logic [STAT_WIDTH-1:0]       stat_misalign
`endif
);

    localparam int DW = INSTR_DATA_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     we_q, we_d;
    logic                     signed_q, signed_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]            mem_data_q, mem_data_d;
    logic                     mem_w_en_q, mem_w_en_d;
    logic [1:0]               mem_sel_q, mem_sel_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [DW-1:0]            resp_rdata_q, resp_rdata_d;
    logic                     resp_misalign_q, resp_misalign_d;

    logic          w_aligned;
    logic          w_accept;
    logic [DW-1:0] w_load_ext;

    always_comb begin
        case (req_size)
            2'b00:   w_aligned = (req_addr[1:0] == 2'b00);
            2'b01:   w_aligned = (req_addr[0] == 1'b0);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_accept = req_valid && (state_q == S_IDLE);

    // Extraction keys off the captured memory select, so size 11 already reads as byte.
    always_comb begin
        case (mem_sel_q)
            2'b00:   w_load_ext = mem_rdata;
            2'b01:   w_load_ext = {{(DW-16){signed_q & mem_rdata[15]}}, mem_rdata[15:0]};
            default: w_load_ext = {{(DW-8){signed_q & mem_rdata[7]}}, mem_rdata[7:0]};
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_accept) state_d = w_aligned ? S_ACCESS : S_RESP;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        we_d            = we_q;
        signed_d        = signed_q;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;
        mem_sel_d       = mem_sel_q;
        mem_w_en_d      = 1'b0;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        resp_misalign_d = resp_misalign_q;
        if (w_accept) begin
            we_d     = req_we;
            signed_d = req_signed;
            if (w_aligned) begin
                mem_addr_d = req_addr;
                mem_data_d = req_wdata;
                mem_sel_d  = (req_size == 2'b11) ? 2'b10 : req_size;
                mem_w_en_d = req_we;
            end else begin
                resp_valid_d    = 1'b1;
                resp_misalign_d = 1'b1;
                resp_rdata_d    = '0;
            end
        end else if (state_q == S_ACCESS) begin
            resp_valid_d    = 1'b1;
            resp_misalign_d = 1'b0;
            resp_rdata_d    = we_q ? '0 : w_load_ext;
        end
    end

    assign req_ready = (state_q == S_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            we_q            <= 1'b0;
            signed_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
            mem_sel_q       <= 2'b00;
            mem_w_en_q      <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_misalign_q <= 1'b0;
        end else begin
            we_q            <= we_d;
            signed_q        <= signed_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            mem_sel_q       <= mem_sel_d;
            mem_w_en_q      <= mem_w_en_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_misalign_q <= resp_misalign_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign mem_sel       = mem_sel_q;
    assign mem_w_en      = mem_w_en_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_misalign = resp_misalign_q;

`ifdef MAU_STATS_EN
    logic [STAT_WIDTH-1:0] stat_loads_q, stat_loads_d;
    logic [STAT_WIDTH-1:0] stat_stores_q, stat_stores_d;
    logic [STAT_WIDTH-1:0] stat_misalign_q, stat_misalign_d;

    // A misaligned access counts only as misaligned, never as a load or store.
    always_comb begin
        stat_loads_d    = stat_loads_q;
        stat_stores_d   = stat_stores_q;
        stat_misalign_d = stat_misalign_q;
        if (state_q == S_RESP) begin
            if (resp_misalign_q) begin
                if (!(&stat_misalign_q)) stat_misalign_d = stat_misalign_q + STAT_WIDTH'(1);
            end else if (we_q) begin
                if (!(&stat_stores_q)) stat_stores_d = stat_stores_q + STAT_WIDTH'(1);
            end else begin
                if (!(&stat_loads_q)) stat_loads_d = stat_loads_q + STAT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stat_loads_q    <= '0;
            stat_stores_q   <= '0;
            stat_misalign_q <= '0;
        end else begin
            stat_loads_q    <= stat_loads_d;
            stat_stores_q   <= stat_stores_d;
            stat_misalign_q <= stat_misalign_d;
        end
    end

    assign stat_loads    = stat_loads_q;
    assign stat_stores   = stat_stores_q;
    assign stat_misalign = stat_misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit with a small byte memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_w_en;
    logic [1:0]  mem_sel;
    logic [31:0] mem_rdata;
`ifdef MAU_STATS_EN
    logic [15:0] stat_loads;
    logic [15:0] stat_stores;
    logic [15:0] stat_misalign;
`endif

    mem_access_unit #(
        .ADDRESS_WIDTH   (32),
        .INSTR_DATA_WIDTH(32),
        .STAT_WIDTH      (16)
    ) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_misalign(resp_misalign),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_w_en     (mem_w_en),
        .mem_sel      (mem_sel),
        .mem_rdata    (mem_rdata)
`ifdef MAU_STATS_EN
        ,
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_misalign(stat_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte memory with combinational word read
    logic [7:0] mem [256];
    logic [7:0] ma;
    assign ma = mem_addr[7:0];
    assign mem_rdata = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)], mem[8'(ma + 8'd1)], mem[ma]};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_w_en) begin
            mem[ma] <= mem_data[7:0];
            if (mem_sel == 2'b00 || mem_sel == 2'b01) mem[8'(ma + 8'd1)] <= mem_data[15:8];
            if (mem_sel == 2'b00) begin
                mem[8'(ma + 8'd2)] <= mem_data[23:16];
                mem[8'(ma + 8'd3)] <= mem_data[31:24];
            end
        end
    end

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.nm, "_rdata"}, resp_rdata, e.rd);
                chk({e.nm, "_misalign"}, {31'd0, resp_misalign}, {31'd0, e.mis});
            end
        end
    end

    task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] ex_rd, input logic ex_mis);
        int          cyc;
        int          wen_cnt;
        logic [1:0]  sel_seen;
        exp_t        e;
        @(negedge clk);
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        e.rd = ex_rd; e.mis = ex_mis; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0BAD_0BAD;
        cyc      = 0;
        wen_cnt  = 0;
        sel_seen = 2'b11;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_w_en === 1'b1) begin
                wen_cnt++;
                sel_seen = mem_sel;
            end
            if (resp_valid === 1'b1) break;
        end
        chk({nm, "_latency"}, cyc, ex_mis ? 32'd1 : 32'd2);
        chk({nm, "_wen_cycles"}, wen_cnt, (we && !ex_mis) ? 32'd1 : 32'd0);
        if (we && !ex_mis)
            chk({nm, "_sel"}, {30'd0, sel_seen}, (sz == 2'b11) ? 32'd2 : {30'd0, sz});
        @(negedge clk);
        chk({nm, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({nm, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_misalign", {31'd0, resp_misalign}, 32'd0);
        chk("rst_wen", {31'd0, mem_w_en}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data", mem_data, 32'd0);
        chk("rst_sel", {30'd0, mem_sel}, 32'd0);
        rst_n = 1'b1;

        // Word store/load
        do_req("sw40", 1'b1, 2'b00, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("lw40", 1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
        // Byte store/load, neighbours preserved
        do_req("sb41", 1'b1, 2'b10, 1'b0, 32'h41, 32'h00000080, 32'h0, 1'b0);
        do_req("lb41", 1'b0, 2'b10, 1'b1, 32'h41, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req("lbu41", 1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h00000080, 1'b0);
        do_req("lw40_after_sb", 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'hDEAD80EF, 1'b0);
        do_req("lb43_size11", 1'b0, 2'b11, 1'b1, 32'h43, 32'h0, 32'hFFFFFFDE, 1'b0);
        do_req("lhu42", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h0000DEAD, 1'b0);
        // Halfword store/load
        do_req("sh44", 1'b1, 2'b01, 1'b0, 32'h44, 32'h00008001, 32'h0, 1'b0);
        do_req("lh44", 1'b0, 2'b01, 1'b1, 32'h44, 32'h0, 32'hFFFF8001, 1'b0);
        do_req("lhu44", 1'b0, 2'b01, 1'b0, 32'h44, 32'h0, 32'h00008001, 1'b0);
        // Misaligned accesses
        do_req("lw42_mis", 1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1);
        do_req("sh45_mis", 1'b1, 2'b01, 1'b0, 32'h45, 32'h12345678, 32'h0, 1'b1);
        do_req("lw44_after_mis", 1'b0, 2'b00, 1'b0, 32'h44, 32'h0, 32'h00008001, 1'b0);

        // Reset during the ACCESS cycle of a store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr  = 32'h48; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rst_mid_wen_before", {31'd0, mem_w_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wen_after", {31'd0, mem_w_en}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
`ifdef MAU_STATS_EN
        chk("stat_loads_cleared", {16'd0, stat_loads}, 32'd0);
`endif
        do_req("lw48_dropped", 1'b0, 2'b00, 1'b0, 32'h48, 32'h0, 32'h0, 1'b0);

        // Store data taken from low bits only
        do_req("sw4c", 1'b1, 2'b00, 1'b0, 32'h4C, 32'h11223344, 32'h0, 1'b0);
        do_req("sb4c", 1'b1, 2'b10, 1'b0, 32'h4C, 32'hFFFFFFA5, 32'h0, 1'b0);
        do_req("lw4c", 1'b0, 2'b00, 1'b1, 32'h4C, 32'h0, 32'h112233A5, 1'b0);
        do_req("lbu4f", 1'b0, 2'b10, 1'b0, 32'h4F, 32'h0, 32'h00000011, 1'b0);
        do_req("lw4e_mis", 1'b0, 2'b00, 1'b0, 32'h4E, 32'h0, 32'h0, 1'b1);

`ifdef MAU_STATS_EN
        chk("stat_loads", {16'd0, stat_loads}, 32'd3);
        chk("stat_stores", {16'd0, stat_stores}, 32'd2);
        chk("stat_misalign", {16'd0, stat_misalign}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
